lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
Parametrised successor to the fixed 640x480 LCD sync block. It generates the LCD panel timing from a full front-porch/sync/back-porch parameter set with programmable sync polarity. It also runs one image window whose position is programmable at runtime and takes effect only on a frame boundary. It produces a registered image-ROM read address with no multiplier, and sits between the pixel clock domain and the image ROM/frame-buffer read port.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
IMG_W, 200, image width (pixels)
IMG_H, 164, image height (lines)
ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  pixel clock
rest_n  in  1  asynchronous active-low reset
en  in  1  timing enable; low holds counters at 0
img_x_in  in  CNT_W  requested window X (active-area coordinates)
img_y_in  in  CNT_W  requested window Y
pos_wr  in  1  one-cycle strobe that loads img_x_in/img_y_in into the shadow registers
lcd_clk  out  1  clk gated by rest_n (0 in reset)
lcd_pwm  out  1  backlight; 1 when rest_n high and en high
lcd_hsync  out  1  registered hsync, polarity HS_POL
lcd_vsync  out  1  registered vsync, polarity VS_POL
lcd_de  out  1  registered data enable
hsync_cnt  out  CNT_W  registered horizontal count, aligned with lcd_de
vsync_cnt  out  CNT_W  registered vertical count
frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0
line_start  out  1  one-cycle pulse at each hcnt=0
img_ack  out  1  pixel is inside the window and inside the active area
addr  out  ADDR_W  image ROM address; 0 when img_ack is low

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL is formed the same way. hcnt runs 0..H_TOTAL-1, then wraps. vcnt increments on each hcnt wrap, runs 0..V_TOTAL-1, then wraps.
- Region order within each line is sync, back porch, active, front porch; frames use the same order. Active h: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE; vertical active is analogous.
- All outputs except lcd_clk and lcd_pwm are registered. Each is valid one cycle after the counter state it decodes. hsync_cnt and vsync_cnt carry the same one-cycle delay, so the counts and strobes stay aligned.
- Reset values: counters 0; lcd_hsync = ~HS_POL; lcd_vsync = ~VS_POL; lcd_de, img_ack, frame_start, line_start all 0; addr 0. Shadow and active positions reset to 0.
- en low: counters are forced to 0 and held; de, img_ack and pulses are 0; syncs are inactive. On en rising, the counters start from 0, so frame_start appears on the first enabled cycle plus 1.
- Position update: pos_wr loads the shadow registers. The active img_x/img_y copy from the shadow only when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 (end of frame). A pos_wr coinciding with that cycle is committed in the same cycle. Writes during a frame never tear the image.
- Window: ha = hcnt-(H_SYNC+H_BP), va = vcnt-(V_SYNC+V_BP). The window hit is active && img_x<=ha<img_x+IMG_W && img_y<=va<img_y+IMG_H. All comparisons are done at CNT_W+1 bits so the sums cannot overflow.
- Clipping: window parts outside the active area give img_ack=0. Addresses of visible pixels remain row*IMG_W+col.
- Address generation uses no multiplier:
  - row_base resets to 0 at frame_start.
  - row_base adds IMG_W at the end of every line whose va lies inside the window rows.
  - addr = row_base + (ha - img_x), registered, and forced to 0 when there is no hit.
- Reset asserted mid-frame clears everything asynchronously. Timing restarts at hcnt=0 after release.

Decomposition:
- Package lcd_timing_pkg holds the derived localparams (H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START) as functions of the parameters, plus the region encoding for debug.
- One natural sub-module, lcd_axis_cnt, is instantiated twice (horizontal, vertical). It has an advance input, a TOTAL parameter, and outputs for count, wrap, and sync/active region flags.

Test Plan:
- Reset then default parameters, run 2 frames:
  - period between frame_start pulses = 800*525 = 420000 clocks;
  - lcd_hsync high for cycles 0..95 of each line;
  - lcd_de high for 640 clocks per line on 480 lines.
- Window at (0,0):
  - first img_ack at hsync_cnt=144, vsync_cnt=35 with addr=0;
  - last ack of row 0 has addr=199;
  - first ack of row 1 has addr=200;
  - last addr of the frame = 32799.
- pos_wr with x=500, y=400 mid-frame: the current frame is unchanged. The next frame clips at ha=639, so each row has 140 acks, and row r starts at addr=r*200. Rows 80..163 get no ack.
- HS_POL=0, VS_POL=0 with a non-default porch set: syncs are idle-high during reset and low only inside the sync region, and the frame period equals the new H_TOTAL*V_TOTAL.
- Drop en mid-line for 10 cycles, then raise it: de and img_ack are 0 while en is low, and frame_start fires one cycle after en rises. Assert rest_n=0 mid-window: addr and img_ack go 0 immediately.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the LCD timing generator: derived timing helpers and
// the per-axis region encoding used by the counter decode.
package lcd_timing_pkg;

    // Region order inside a line and inside a frame.
    typedef enum logic [1:0] {
        REG_SYNC   = 2'd0,
        REG_BP     = 2'd1,
        REG_ACTIVE = 2'd2,
        REG_FP     = 2'd3
    } region_e;

    function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int act_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    function automatic int act_end(input int sync, input int bp, input int active);
        return sync + bp + active;
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: a wrapping counter that steps on 'advance' and decodes its
// current sync/back-porch/active/front-porch region.
module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int TOTAL  = 800,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic             en,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             in_active
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Thresholds are one bit wider so an active region ending exactly at
    // TOTAL still compares correctly.
    localparam logic [CNT_W:0] SYNC_END  = (CNT_W + 1)'(SYNC);
    localparam logic [CNT_W:0] ACT_START = (CNT_W + 1)'(act_start(SYNC, BP));
    localparam logic [CNT_W:0] ACT_END   = (CNT_W + 1)'(act_end(SYNC, BP, ACTIVE));

    logic [CNT_W:0] count_x;
    region_e        region;

    assign wrap    = en && advance && (count == LAST);
    assign count_x = {1'b0, count};

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every reader sees the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

    // NOTE: the region gets a default before any condition so this decode can
    // never infer a latch.
    always_comb begin
        region = REG_FP;
        if (count_x < SYNC_END) begin
            region = REG_SYNC;
        end else if (count_x < ACT_START) begin
            region = REG_BP;
        end else if (count_x < ACT_END) begin
            region = REG_ACTIVE;
        end
    end

    assign in_sync   = (region == REG_SYNC);
    assign in_active = (region == REG_ACTIVE);

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD timing generator with a frame-synchronous image window and
// a multiplier-free, registered image-ROM read address.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 11,
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 164,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rest_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  img_x_in,
    input  logic [CNT_W-1:0]  img_y_in,
    input  logic              pos_wr,
    output logic              lcd_clk,
    output logic              lcd_pwm,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic              lcd_de,
    output logic [CNT_W-1:0]  hsync_cnt,
    output logic [CNT_W-1:0]  vsync_cnt,
    output logic              frame_start,
    output logic              line_start,
    output logic              img_ack,
    output logic [ADDR_W-1:0] addr
);

    localparam int H_TOTAL     = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL     = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int H_ACT_START = act_start(H_SYNC, H_BP);
    localparam int V_ACT_START = act_start(V_SYNC, V_BP);
    localparam int W1          = CNT_W + 1;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;

    lcd_axis_cnt #(
        .TOTAL (H_TOTAL),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .ACTIVE(H_ACTIVE),
        .CNT_W (CNT_W)
    ) u_h_cnt (
        .clk      (clk),
        .rest_n   (rest_n),
        .en       (en),
        .advance  (1'b1),
        .count    (hcnt),
        .wrap     (h_wrap),
        .in_sync  (h_sync),
        .in_active(h_act)
    );

    lcd_axis_cnt #(
        .TOTAL (V_TOTAL),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .ACTIVE(V_ACTIVE),
        .CNT_W (CNT_W)
    ) u_v_cnt (
        .clk      (clk),
        .rest_n   (rest_n),
        .en       (en),
        .advance  (h_wrap),
        .count    (vcnt),
        .wrap     (v_wrap),
        .in_sync  (v_sync),
        .in_active(v_act)
    );

    assign lcd_clk = clk & rest_n;
    assign lcd_pwm = rest_n & en;

    // Window position: software writes land in the shadow copy; the live copy
    // only changes on the last pixel of a frame so an image is never torn.
    logic [CNT_W-1:0] shadow_x, shadow_y, img_x, img_y;
    logic             frame_end;

    assign frame_end = h_wrap && v_wrap;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            shadow_x <= '0;
            shadow_y <= '0;
            img_x    <= '0;
            img_y    <= '0;
        end else begin
            if (pos_wr) begin
                shadow_x <= img_x_in;
                shadow_y <= img_y_in;
            end
            if (frame_end) begin
                img_x <= pos_wr ? img_x_in : shadow_x;
                img_y <= pos_wr ? img_y_in : shadow_y;
            end
        end
    end

    // Window decode, one bit wider than the counters so x+IMG_W cannot wrap.
    logic [W1-1:0]     ha, va, x0, y0;
    logic              col_hit, row_hit, hit;
    logic [ADDR_W-1:0] row_base, addr_next;

    assign ha      = W1'(hcnt) - W1'(H_ACT_START);
    assign va      = W1'(vcnt) - W1'(V_ACT_START);
    assign x0      = W1'(img_x);
    assign y0      = W1'(img_y);
    assign col_hit = (ha >= x0) && (ha < x0 + W1'(IMG_W));
    assign row_hit = v_act && (va >= y0) && (va < y0 + W1'(IMG_H));
    assign hit     = h_act && col_hit && row_hit;

    // row_base holds row*IMG_W for the current window row, built by repeated
    // addition at each line end instead of a multiply.
    assign addr_next = row_base + ADDR_W'(ha - x0);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            lcd_hsync   <= ~HS_POL;
            lcd_vsync   <= ~VS_POL;
            lcd_de      <= 1'b0;
            hsync_cnt   <= '0;
            vsync_cnt   <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            img_ack     <= 1'b0;
            addr        <= '0;
            row_base    <= '0;
        end else if (!en) begin
            lcd_hsync   <= ~HS_POL;
            lcd_vsync   <= ~VS_POL;
            lcd_de      <= 1'b0;
            hsync_cnt   <= '0;
            vsync_cnt   <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            img_ack     <= 1'b0;
            addr        <= '0;
            row_base    <= '0;
        end else begin
            lcd_hsync   <= h_sync ? HS_POL : ~HS_POL;
            lcd_vsync   <= v_sync ? VS_POL : ~VS_POL;
            lcd_de      <= h_act && v_act;
            hsync_cnt   <= hcnt;
            vsync_cnt   <= vcnt;
            frame_start <= (hcnt == '0) && (vcnt == '0);
            line_start  <= (hcnt == '0);
            img_ack     <= hit;
            addr        <= hit ? addr_next : '0;
            if (h_wrap) begin
                if (v_wrap) begin
                    row_base <= '0;
                end else if (row_hit) begin
                    row_base <= row_base + ADDR_W'(IMG_W);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: a frame-arithmetic reference model
// predicts every output cycle, a separate monitor pops and compares.
module tb_lcd_timing_gen;

    // Reduced timing so several frames fit in a short run.
    localparam int HA = 40, HFP = 4, HSY = 6, HBP = 5;
    localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HSY + HBP + HA + HFP;
    localparam int VT = VSY + VBP + VA + VFP;
    localparam int HAS = HSY + HBP, VAS = VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int IW = 12, IH = 8;

    localparam int HA_B = 20, HFP_B = 3, HSY_B = 4, HBP_B = 2;
    localparam int VA_B = 10, VFP_B = 1, VSY_B = 3, VBP_B = 2;
    localparam int HT_B = HSY_B + HBP_B + HA_B + HFP_B;
    localparam int VT_B = VSY_B + VBP_B + VA_B + VFP_B;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       ls;
        logic       ack;
        logic [7:0] hc;
        logic [7:0] vc;
        logic [7:0] addr;
    } out_t;

    logic       clk = 1'b0;
    logic       rest_n, en, pos_wr;
    logic [7:0] img_x_in, img_y_in;

    logic       a_lcd_clk, a_lcd_pwm, a_hsync, a_vsync, a_de, a_fs, a_ls, a_ack;
    logic [7:0] a_hc, a_vc, a_addr;

    logic       en_b = 1'b1, pos_wr_b = 1'b0;
    logic [7:0] x_b = '0, y_b = '0;
    logic       b_lcd_clk, b_lcd_pwm, b_hsync, b_vsync, b_de, b_fs, b_ls, b_ack;
    logic [7:0] b_hc, b_vc, b_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(8)
    ) dut_a (
        .clk(clk), .rest_n(rest_n), .en(en),
        .img_x_in(img_x_in), .img_y_in(img_y_in), .pos_wr(pos_wr),
        .lcd_clk(a_lcd_clk), .lcd_pwm(a_lcd_pwm),
        .lcd_hsync(a_hsync), .lcd_vsync(a_vsync), .lcd_de(a_de),
        .hsync_cnt(a_hc), .vsync_cnt(a_vc),
        .frame_start(a_fs), .line_start(a_ls),
        .img_ack(a_ack), .addr(a_addr)
    );

    lcd_timing_gen #(
        .H_ACTIVE(HA_B), .H_FP(HFP_B), .H_SYNC(HSY_B), .H_BP(HBP_B),
        .V_ACTIVE(VA_B), .V_FP(VFP_B), .V_SYNC(VSY_B), .V_BP(VBP_B),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(8),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(8)
    ) dut_b (
        .clk(clk), .rest_n(rest_n), .en(en_b),
        .img_x_in(x_b), .img_y_in(y_b), .pos_wr(pos_wr_b),
        .lcd_clk(b_lcd_clk), .lcd_pwm(b_lcd_pwm),
        .lcd_hsync(b_hsync), .lcd_vsync(b_vsync), .lcd_de(b_de),
        .hsync_cnt(b_hc), .vsync_cnt(b_vc),
        .frame_start(b_fs), .line_start(b_ls),
        .img_ack(b_ack), .addr(b_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic out_t sample_a();
        out_t s;
        s = '{hs: a_hsync, vs: a_vsync, de: a_de, fs: a_fs, ls: a_ls, ack: a_ack,
              hc: a_hc, vc: a_vc, addr: a_addr};
        return s;
    endfunction

    // Reference model: position index since counting started, plus window state.
    out_t sb_q[$];
    out_t m_last;
    int   m_p = 0;
    int   m_sx = 0, m_sy = 0, m_ix = 0, m_iy = 0;

    task automatic model_reset();
        m_p = 0;
        m_sx = 0; m_sy = 0; m_ix = 0; m_iy = 0;
    endtask

    // Called at a negedge with inputs set: predicts the outputs after the next
    // posedge, pushes them, and waits for the following negedge.
    task automatic tick();
        out_t e;
        int   h, v, ha, va;
        bit   act;
        e = '0;
        if (en) begin
            h   = m_p % HT;
            v   = (m_p / HT) % VT;
            ha  = h - HAS;
            va  = v - VAS;
            act = (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
            e.hs  = (h < HSY);
            e.vs  = (v < VSY);
            e.de  = act;
            e.fs  = (h == 0) && (v == 0);
            e.ls  = (h == 0);
            e.hc  = 8'(h);
            e.vc  = 8'(v);
            e.ack = act && (ha >= m_ix) && (ha < m_ix + IW) && (va >= m_iy) && (va < m_iy + IH);
            e.addr = e.ack ? 8'((va - m_iy) * IW + (ha - m_ix)) : 8'd0;
            if (pos_wr) begin
                m_sx = img_x_in;
                m_sy = img_y_in;
            end
            if (h == HT - 1 && v == VT - 1) begin
                m_ix = m_sx;
                m_iy = m_sy;
            end
            m_p++;
        end else begin
            m_p = 0;
            if (pos_wr) begin
                m_sx = img_x_in;
                m_sy = img_y_in;
            end
        end
        m_last = e;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor for the main instance.
    initial begin : mon_a
        out_t exp_o, act_o;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_o = sb_q.pop_front();
                act_o = sample_a();
                check("scoreboard", act_o, exp_o);
            end
        end
    end

    // Independent checker for the inverted-polarity instance (en tied high).
    initial begin : mon_b
        int   b_p, b_last_fs, h, v;
        logic [3:0] exp_v;
        b_p = 0;
        b_last_fs = -1;
        forever begin
            @(posedge clk);
            #1;
            if (!rest_n) begin
                b_p = 0;
                b_last_fs = -1;
            end else begin
                h = b_p % HT_B;
                v = (b_p / HT_B) % VT_B;
                exp_v[3] = !(h < HSY_B);
                exp_v[2] = !(v < VSY_B);
                exp_v[1] = (h >= HSY_B + HBP_B) && (h < HSY_B + HBP_B + HA_B)
                        && (v >= VSY_B + VBP_B) && (v < VSY_B + VBP_B + VA_B);
                exp_v[0] = (h == 0) && (v == 0);
                check("b_sync_de_fs", {b_hsync, b_vsync, b_de, b_fs}, exp_v);
                if (b_fs) begin
                    if (b_last_fs >= 0) check("b_frame_period", b_p - b_last_fs, HT_B * VT_B);
                    b_last_fs = b_p;
                end
                b_p++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        out_t s;
        int   last_fs, de_cnt, hs_cnt, max_addr, fa_hc, fa_vc, fa_addr, ack_cnt, low_left;
        bit   found;

        rest_n = 1'b0; en = 1'b0; pos_wr = 1'b0; img_x_in = '0; img_y_in = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_a_outputs", sample_a(), 30'd0);
        check("rst_a_pwm", a_lcd_pwm, 1'b0);
        check("rst_b_syncs_idle_high", {b_hsync, b_vsync}, 2'b11);
        @(posedge clk);
        #1;
        check("rst_lcd_clk_low", a_lcd_clk, 1'b0);
        @(negedge clk);

        rest_n = 1'b1;
        en = 1'b1;
        #1;
        check("pwm_on", a_lcd_pwm, 1'b1);

        // Two frames with the window at (0,0).
        last_fs = -1; de_cnt = 0; hs_cnt = 0; max_addr = -1;
        fa_hc = -1; fa_vc = -1; fa_addr = -1;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            tick();
            s = sample_a();
            if (s.fs) begin
                if (last_fs >= 0) check("frame_period", i - last_fs, FRAME);
                last_fs = i;
            end
            if (i < FRAME) begin
                de_cnt += int'(s.de);
                hs_cnt += int'(s.hs);
                if (s.ack) begin
                    if (fa_hc < 0) begin
                        fa_hc = s.hc; fa_vc = s.vc; fa_addr = s.addr;
                    end
                    if (int'(s.addr) > max_addr) max_addr = s.addr;
                end
            end
        end
        check("de_per_frame", de_cnt, HA * VA);
        check("hs_per_frame", hs_cnt, HSY * VT);
        check("first_ack_h", fa_hc, HAS);
        check("first_ack_v", fa_vc, VAS);
        check("first_ack_addr", fa_addr, 0);
        check("last_addr_frame", max_addr, IW * IH - 1);

        // Mid-frame write that clips both right and bottom edges.
        repeat (20 * HT) tick();
        pos_wr = 1'b1; img_x_in = 8'd34; img_y_in = 8'd26;
        tick();
        pos_wr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FRAME + 1; i++) begin
            tick();
            if (sample_a().fs) begin
                found = 1'b1;
                break;
            end
        end
        check("next_frame_reached", found, 1'b1);
        ack_cnt = 0; max_addr = -1;
        for (int i = 0; i < FRAME - 1; i++) begin
            tick();
            s = sample_a();
            if (s.ack) begin
                ack_cnt++;
                if (int'(s.addr) > max_addr) max_addr = s.addr;
            end
        end
        check("clipped_ack_count", ack_cnt, (HA - 34) * (VA - 26));
        check("clipped_max_addr", max_addr, (VA - 26 - 1) * IW + (HA - 34 - 1));

        // Drop en mid-line for 10 cycles.
        repeat (7) tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            s = sample_a();
            check("en_low_quiet", {s.de, s.ack, s.fs, s.hs}, 4'b0);
        end
        en = 1'b1;
        tick();
        check("fs_after_en_rise", sample_a().fs, 1'b1);

        // Write landing exactly on the frame-end cycle.
        for (int i = 0; i < FRAME + 1 && (m_p % FRAME) != FRAME - 1; i++) tick();
        pos_wr = 1'b1; img_x_in = 8'd3; img_y_in = 8'd2;
        tick();
        pos_wr = 1'b0;
        repeat (FRAME) tick();

        // Randomised window writes and enable drops.
        low_left = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (low_left > 0) begin
                en = 1'b0;
                low_left--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 599) == 0) low_left = $urandom_range(1, 15);
            end
            pos_wr = ($urandom_range(0, 299) == 0);
            if (pos_wr) begin
                img_x_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 45));
                img_y_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 35));
            end
            tick();
        end
        pos_wr = 1'b0;
        en = 1'b1;

        // Asynchronous reset in the middle of the window.
        pos_wr = 1'b1; img_x_in = 8'd5; img_y_in = 8'd5;
        tick();
        pos_wr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (m_last.ack && m_last.addr > 8'd20) begin
                found = 1'b1;
                break;
            end
        end
        check("window_reached_before_reset", found, 1'b1);
        #1;
        rest_n = 1'b0;
        #1;
        check("async_rst_ack_addr", {a_ack, a_addr}, 9'd0);
        check("async_rst_b_syncs_idle_high", {b_hsync, b_vsync}, 2'b11);
        @(negedge clk);
        @(negedge clk);
        rest_n = 1'b1;
        model_reset();
        tick();
        s = sample_a();
        check("restart_fs_at_h0", {s.fs, s.hc, s.vc}, 17'h10000);
        repeat (FRAME + 10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
